// File: rtl/gumnut_pkg.sv
// Shared Gumnut encodings: opcode-class prefixes, function codes, decode bit
// indices, fetch FSM state codes and an IR field-slice helper for execute.
package gumnut_pkg;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_FETCH        = 2'd1;
    localparam logic [1:0] S_WAIT_CONSUME = 2'd2;

    localparam int DEC_W         = 7;
    localparam int DEC_ALU_IMMED = 0;
    localparam int DEC_MEM       = 1;
    localparam int DEC_SHIFT     = 2;
    localparam int DEC_ALU_REG   = 3;
    localparam int DEC_JUMP      = 4;
    localparam int DEC_BRANCH    = 5;
    localparam int DEC_MISC      = 6;

    // Class prefixes, matched MSB-first against ir[17:...]
    localparam logic       PFX_ALU_IMMED = 1'b0;
    localparam logic [1:0] PFX_MEM       = 2'b10;
    localparam logic [2:0] PFX_SHIFT     = 3'b110;
    localparam logic [3:0] PFX_ALU_REG   = 4'b1110;
    localparam logic [4:0] PFX_JUMP      = 5'b11110;
    localparam logic [5:0] PFX_BRANCH    = 6'b111110;
    localparam logic [6:0] PFX_MISC      = 7'b1111110;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_ADDC = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_SUBC = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_MASK = 3'b111;

    localparam logic [1:0] SHIFT_SHL = 2'b00;
    localparam logic [1:0] SHIFT_SHR = 2'b01;
    localparam logic [1:0] SHIFT_ROL = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [1:0] MEM_LDM = 2'b00;
    localparam logic [1:0] MEM_STM = 2'b01;
    localparam logic [1:0] MEM_INP = 2'b10;
    localparam logic [1:0] MEM_OUT = 2'b11;

    localparam logic [1:0] BR_BZ  = 2'b00;
    localparam logic [1:0] BR_BNZ = 2'b01;
    localparam logic [1:0] BR_BC  = 2'b10;
    localparam logic [1:0] BR_BNC = 2'b11;

    localparam logic JMP_JMP = 1'b0;
    localparam logic JMP_JSB = 1'b1;

    localparam logic [2:0] MISC_RET  = 3'b000;
    localparam logic [2:0] MISC_RETI = 3'b001;
    localparam logic [2:0] MISC_ENAI = 3'b010;
    localparam logic [2:0] MISC_DISI = 3'b011;
    localparam logic [2:0] MISC_WAIT = 3'b100;
    localparam logic [2:0] MISC_STBY = 3'b101;

    typedef struct packed {
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rs2;
        logic [2:0]  count;
        logic [7:0]  immed;
        logic [7:0]  disp;
        logic [11:0] addr;
    } ir_fields_t;

    // Raw slices; which ones are meaningful depends on the decoded class.
    function automatic ir_fields_t ir_fields(input logic [17:0] ir);
        ir_fields_t f;
        f.rd    = ir[13:11];
        f.rs    = ir[10:8];
        f.rs2   = ir[7:5];
        f.count = ir[7:5];
        f.immed = ir[7:0];
        f.disp  = ir[7:0];
        f.addr  = ir[11:0];
        return f;
    endfunction

endpackage

// File: rtl/gumnut_inst_decode.sv
// Combinational IR -> one-hot instruction class; all-ones prefix (illegal)
// and an empty IR both decode to zero. Field slices come from ir_fields().
module gumnut_inst_decode
    import gumnut_pkg::*;
(
    input  logic [17:0]      ir_i,
    input  logic             ir_valid_i,
    output logic [DEC_W-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (ir_valid_i) begin
            if (ir_i[17] == PFX_ALU_IMMED)        dec_o[DEC_ALU_IMMED] = 1'b1;
            else if (ir_i[17:16] == PFX_MEM)      dec_o[DEC_MEM]       = 1'b1;
            else if (ir_i[17:15] == PFX_SHIFT)    dec_o[DEC_SHIFT]     = 1'b1;
            else if (ir_i[17:14] == PFX_ALU_REG)  dec_o[DEC_ALU_REG]   = 1'b1;
            else if (ir_i[17:13] == PFX_JUMP)     dec_o[DEC_JUMP]      = 1'b1;
            else if (ir_i[17:12] == PFX_BRANCH)   dec_o[DEC_BRANCH]    = 1'b1;
            else if (ir_i[17:11] == PFX_MISC)     dec_o[DEC_MISC]      = 1'b1;
        end
    end

endmodule

// File: rtl/gumnut_fetch_unit.sv
// Gumnut fetch stage: PC, instruction bus master, IR plus optional one-entry
// prefetch buffer, valid/ready handoff to execute and redirect handling.
module gumnut_fetch_unit
    import gumnut_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter bit          PREFETCH = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    input  logic        inst_ack_i,
    output logic [11:0] inst_adr_o,
    input  logic [17:0] inst_dat_i,
    output logic        ir_valid_o,
    input  logic        ir_ready_i,
    output logic [17:0] ir_o,
    output logic [11:0] pc_o,
    output logic [11:0] pc_next_o,
    output logic [6:0]  dec_o,
    input  logic        redirect_i,
    input  logic [11:0] redirect_adr_i
);

    logic [1:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [17:0] ir_q, ir_d;
    logic [11:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [17:0] buf_q, buf_d;
    logic [11:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;

    logic consume;
    logic ir_slot_free;

    assign consume      = ir_valid_q & ir_ready_i;
    assign ir_slot_free = ~ir_valid_q | ir_ready_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        buf_d       = buf_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;

        if (redirect_i) begin
            // IDLE doubles as the one-cycle bus abort before refetching
            pc_d        = redirect_adr_i;
            ir_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;

                S_FETCH: begin
                    if (consume) ir_valid_d = 1'b0;
                    if (inst_ack_i) begin
                        pc_d = pc_q + 12'd1;
                        if (ir_slot_free) begin
                            ir_d       = inst_dat_i;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            if (!PREFETCH) state_d = S_WAIT_CONSUME;
                        end else begin
                            buf_d       = inst_dat_i;
                            buf_pc_d    = pc_q;
                            buf_valid_d = 1'b1;
                            state_d     = S_WAIT_CONSUME;
                        end
                    end
                end

                S_WAIT_CONSUME: begin
                    if (consume) begin
                        if (buf_valid_q) begin
                            ir_d        = buf_q;
                            ir_pc_d     = buf_pc_q;
                            buf_valid_d = 1'b0;
                        end else begin
                            ir_valid_d = 1'b0;
                        end
                        state_d = S_FETCH;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_pc_q     <= RESET_PC;
            ir_valid_q  <= 1'b0;
            buf_q       <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            buf_q       <= buf_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign inst_cyc_o = (state_q == S_FETCH);
    assign inst_stb_o = (state_q == S_FETCH);
    assign inst_adr_o = pc_q;
    assign ir_valid_o = ir_valid_q;
    assign ir_o       = ir_q;
    assign pc_o       = ir_pc_q;
    assign pc_next_o  = ir_pc_q + 12'd1;

    gumnut_inst_decode u_decode (
        .ir_i       (ir_q),
        .ir_valid_i (ir_valid_q),
        .dec_o      (dec_o)
    );

endmodule

// File: tb/tb_gumnut_fetch_unit.sv
// Directed bench for gumnut_fetch_unit against a small instruction memory
// model with configurable ack wait states.
module tb_gumnut_fetch_unit;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        inst_cyc, inst_stb, inst_ack;
    logic [11:0] inst_adr;
    logic [17:0] inst_dat;
    logic        ir_valid, ir_ready;
    logic [17:0] ir;
    logic [11:0] pc, pc_next;
    logic [6:0]  dec;
    logic        redirect;
    logic [11:0] redirect_adr;

    logic [2:0]  wait_n;
    logic [2:0]  wcnt;
    logic        stray;
    logic        dmode;
    logic [17:0] dtab [8];
    logic [6:0]  dexp [8];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    assign inst_ack = stray | (inst_cyc & inst_stb & (wcnt == wait_n));
    assign inst_dat = dmode ? dtab[inst_adr[2:0]] : ({6'd0, inst_adr} + 18'h100);

    always @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b)                             wcnt <= 3'd0;
        else if (inst_cyc && inst_stb && !inst_ack) wcnt <= wcnt + 3'd1;
        else                                    wcnt <= 3'd0;
    end

    gumnut_fetch_unit dut (
        .clk_i          (clk_sys),
        .rst_i          (rst_b),
        .inst_cyc_o     (inst_cyc),
        .inst_stb_o     (inst_stb),
        .inst_ack_i     (inst_ack),
        .inst_adr_o     (inst_adr),
        .inst_dat_i     (inst_dat),
        .ir_valid_o     (ir_valid),
        .ir_ready_i     (ir_ready),
        .ir_o           (ir),
        .pc_o           (pc),
        .pc_next_o      (pc_next),
        .dec_o          (dec),
        .redirect_i     (redirect),
        .redirect_adr_i (redirect_adr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench on the abort (IDLE) cycle, one cycle before the fetch at a
    task automatic go_to(input logic [11:0] a);
        @(negedge clk_sys);
        redirect     = 1'b1;
        redirect_adr = a;
        @(negedge clk_sys);
        redirect     = 1'b0;
        chk("goto_cyc", {31'd0, inst_cyc}, 32'd0);
        chk("goto_irv", {31'd0, ir_valid}, 32'd0);
        chk("goto_adr", {20'd0, inst_adr}, {20'd0, a});
    endtask

    initial begin
        dtab[0] = 18'h0_0000; dexp[0] = 7'b0000001;
        dtab[1] = 18'h2_0000; dexp[1] = 7'b0000010;
        dtab[2] = 18'h3_0000; dexp[2] = 7'b0000100;
        dtab[3] = 18'h3_8000; dexp[3] = 7'b0001000;
        dtab[4] = 18'h3_C000; dexp[4] = 7'b0010000;
        dtab[5] = 18'h3_E000; dexp[5] = 7'b0100000;
        dtab[6] = 18'h3_F000; dexp[6] = 7'b1000000;
        dtab[7] = 18'h3_F800; dexp[7] = 7'b0000000;

        rst_b = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_adr = 12'h000;
        wait_n = 3'd0; stray = 1'b0; dmode = 1'b0;

        // reset state
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rst_cyc", {31'd0, inst_cyc}, 32'd0);
        chk("rst_stb", {31'd0, inst_stb}, 32'd0);
        chk("rst_adr", {20'd0, inst_adr}, 32'h000);
        chk("rst_irv", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", {14'd0, ir}, 32'h0);
        chk("rst_pc", {20'd0, pc}, 32'h000);
        chk("rst_dec", {25'd0, dec}, 32'h0);
        rst_b = 1'b1;

        // zero-wait streaming
        @(negedge clk_sys);
        chk("s_cyc", {31'd0, inst_cyc}, 32'd1);
        chk("s_adr0", {20'd0, inst_adr}, 32'h000);
        chk("s_irv0", {31'd0, ir_valid}, 32'd0);
        @(negedge clk_sys);
        chk("s_adr1", {20'd0, inst_adr}, 32'h001);
        chk("s_ir0", {14'd0, ir}, 32'h100);
        chk("s_pc0", {20'd0, pc}, 32'h000);
        chk("s_irv1", {31'd0, ir_valid}, 32'd1);
        @(negedge clk_sys);
        chk("s_adr2", {20'd0, inst_adr}, 32'h002);
        chk("s_ir1", {14'd0, ir}, 32'h101);
        chk("s_pc1", {20'd0, pc}, 32'h001);
        @(negedge clk_sys);
        chk("s_ir2", {14'd0, ir}, 32'h102);
        chk("s_pc2", {20'd0, pc}, 32'h002);
        chk("s_dec2", {25'd0, dec}, 32'h01);

        // 3-wait memory
        wait_n = 3'd3;
        go_to(12'h010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            chk("w_stb", {31'd0, inst_stb}, 32'd1);
            chk("w_adr", {20'd0, inst_adr}, 32'h010);
            chk("w_irv", {31'd0, ir_valid}, 32'd0);
        end
        @(negedge clk_sys);
        chk("w_irv_after", {31'd0, ir_valid}, 32'd1);
        chk("w_ir", {14'd0, ir}, 32'h110);
        chk("w_pc", {20'd0, pc}, 32'h010);

        // prefetch stall with a stray ack while idle on the bus
        wait_n = 3'd0;
        go_to(12'h020);
        @(negedge clk_sys);
        chk("p_adr0", {20'd0, inst_adr}, 32'h020);
        @(negedge clk_sys);
        chk("p_ir0", {14'd0, ir}, 32'h120);
        chk("p_adr1", {20'd0, inst_adr}, 32'h021);
        ir_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            chk("p_cyc_hold", {31'd0, inst_cyc}, 32'd0);
            chk("p_ir_hold", {14'd0, ir}, 32'h120);
            chk("p_adr_hold", {20'd0, inst_adr}, 32'h022);
            chk("p_irv_hold", {31'd0, ir_valid}, 32'd1);
            stray = (k == 1);
        end
        @(negedge clk_sys);
        chk("p_cyc_last", {31'd0, inst_cyc}, 32'd0);
        chk("p_ir_last", {14'd0, ir}, 32'h120);
        ir_ready = 1'b1;
        @(negedge clk_sys);
        chk("p_ir_buf", {14'd0, ir}, 32'h121);
        chk("p_pc_buf", {20'd0, pc}, 32'h021);
        chk("p_irv_buf", {31'd0, ir_valid}, 32'd1);
        chk("p_refetch", {20'd0, inst_adr}, 32'h022);
        @(negedge clk_sys);
        chk("p_ir_next", {14'd0, ir}, 32'h122);
        chk("p_adr_next", {20'd0, inst_adr}, 32'h023);

        // redirect in the ack cycle of adr 005
        go_to(12'h003);
        @(negedge clk_sys);
        chk("r_adr3", {20'd0, inst_adr}, 32'h003);
        @(negedge clk_sys);
        chk("r_ir3", {14'd0, ir}, 32'h103);
        @(negedge clk_sys);
        chk("r_adr5", {20'd0, inst_adr}, 32'h005);
        redirect = 1'b1; redirect_adr = 12'h3A0;
        @(negedge clk_sys);
        redirect = 1'b0;
        chk("r_irv", {31'd0, ir_valid}, 32'd0);
        chk("r_cyc", {31'd0, inst_cyc}, 32'd0);
        chk("r_adr_tgt", {20'd0, inst_adr}, 32'h3A0);
        chk("r_dec", {25'd0, dec}, 32'h0);
        @(negedge clk_sys);
        chk("r_cyc_tgt", {31'd0, inst_cyc}, 32'd1);
        chk("r_adr_fetch", {20'd0, inst_adr}, 32'h3A0);
        @(negedge clk_sys);
        chk("r_ir_tgt", {14'd0, ir}, 32'h4A0);
        chk("r_pc_tgt", {20'd0, pc}, 32'h3A0);

        // PC wrap
        go_to(12'hFFF);
        @(negedge clk_sys);
        chk("x_adr", {20'd0, inst_adr}, 32'hFFF);
        @(negedge clk_sys);
        chk("x_ir", {14'd0, ir}, 32'h010FF);
        chk("x_pc", {20'd0, pc}, 32'hFFF);
        chk("x_pc_next", {20'd0, pc_next}, 32'h000);
        chk("x_adr_wrap", {20'd0, inst_adr}, 32'h000);

        // class decode
        dmode = 1'b1;
        go_to(12'h000);
        @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            chk("d_ir", {14'd0, ir}, {14'd0, dtab[i]});
            chk("d_dec", {25'd0, dec}, {25'd0, dexp[i]});
        end
        dmode = 1'b0;

        // async reset during a wait state
        wait_n = 3'd3;
        go_to(12'h050);
        @(negedge clk_sys);
        chk("a_stb_pre", {31'd0, inst_stb}, 32'd1);
        chk("a_adr_pre", {20'd0, inst_adr}, 32'h050);
        #2 rst_b = 1'b0;
        #1;
        chk("a_cyc", {31'd0, inst_cyc}, 32'd0);
        chk("a_stb", {31'd0, inst_stb}, 32'd0);
        chk("a_adr", {20'd0, inst_adr}, 32'h000);
        chk("a_irv", {31'd0, ir_valid}, 32'd0);
        @(negedge clk_sys);
        rst_b = 1'b1; wait_n = 3'd0;
        @(negedge clk_sys);
        chk("a_cyc_rel", {31'd0, inst_cyc}, 32'd1);
        chk("a_adr_rel", {20'd0, inst_adr}, 32'h000);
        @(negedge clk_sys);
        chk("a_ir_rel", {14'd0, ir}, 32'h100);
        chk("a_irv_rel", {31'd0, ir_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
